// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word fetches to instruction
// memory, buffers returned words with their PCs and presents the head entry
// to the memcopy expander.
// Optional build macro: IFU_PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
module instr_fetch_unit #(
   parameter int unsigned       WIDTH       = 32,
   parameter logic [WIDTH-1:0]  RESET_PC    = '0,
   parameter logic [6:0]        MEMC_OPCODE = 7'b0001011,
   parameter int unsigned       FQ_DEPTH    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_en,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] instr_out,
   output logic             valid_out,
   output logic             memc_en
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]      fetch_cnt,
   output logic [31:0]      bubble_cnt
`endif
);

   localparam int unsigned PW = $clog2(FQ_DEPTH);
   localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

   state_t           state;
   logic [WIDTH-1:0] fetch_pc;
   logic [WIDTH-1:0] q_pc    [FQ_DEPTH];
   logic [WIDTH-1:0] q_instr [FQ_DEPTH];
   logic [WIDTH-1:0] tag_pc  [FQ_DEPTH];
   logic [PW-1:0]    q_wr, q_rd, t_wr, t_rd;
   logic [CW-1:0]    count, outstanding, drop;
   logic [CW-1:0]    count_nxt, out_nxt, drop_nxt;
   logic             hs, push, pop, space_nxt;
   logic             unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign hs        = imem_req & imem_gnt;
   assign push      = imem_rvalid & (drop == '0) & ~redirect;
   assign valid_out = (count != '0);
   assign pop       = valid_out & pc_en & ~redirect;
   assign imem_addr = fetch_pc;
   assign pc_out    = valid_out ? q_pc[q_rd]    : fetch_pc;
   assign instr_out = valid_out ? q_instr[q_rd] : NOP;
   assign memc_en   = valid_out & (instr_out[6:0] == MEMC_OPCODE);

   // Next occupancy of queue, in-flight fetches and responses still to discard.
   always_comb begin
      count_nxt = count;
      drop_nxt  = drop;
      out_nxt   = outstanding + CW'(hs) - CW'(imem_rvalid);
      if (redirect) begin
         count_nxt = '0;
         drop_nxt  = out_nxt;
      end else begin
         count_nxt = count + CW'(push) - CW'(pop);
         if (imem_rvalid && drop != '0) drop_nxt = drop - CW'(1);
      end
      space_nxt = (SW'(count_nxt) + SW'(out_nxt)) < SW'(FQ_DEPTH);
   end

   // Counters, pointers and fetch PC; redirect wins over every other update.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         q_wr        <= '0;
         q_rd        <= '0;
         t_wr        <= '0;
         t_rd        <= '0;
      end else begin
         count       <= count_nxt;
         outstanding <= out_nxt;
         drop        <= drop_nxt;
         if (hs)          t_wr <= t_wr + PW'(1);
         if (imem_rvalid) t_rd <= t_rd + PW'(1);
         if (redirect) begin
            fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
            q_wr     <= '0;
            q_rd     <= '0;
         end else begin
            if (hs)   fetch_pc <= fetch_pc + WIDTH'(4);
            if (push) q_wr     <= q_wr + PW'(1);
            if (pop)  q_rd     <= q_rd + PW'(1);
         end
         assert (count_nxt <= CW'(FQ_DEPTH))
            else $error("ifu: fetch queue count out of range");
         assert (out_nxt <= CW'(FQ_DEPTH))
            else $error("ifu: outstanding count out of range");
         assert (drop_nxt <= out_nxt)
            else $error("ifu: drop count exceeds outstanding");
      end
   end

   // PC tag FIFO and fetch-queue payload storage (no reset needed).
   always_ff @(posedge clk) begin
      if (hs) tag_pc[t_wr] <= fetch_pc;
      if (push) begin
         q_pc[q_wr]    <= tag_pc[t_rd];
         q_instr[q_wr] <= imem_rdata;
      end
   end

   // Request-side FSM; imem_req is the registered REQ state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         imem_req <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) begin
                  state <= FLUSH; imem_req <= 1'b0;
               end else if (space_nxt) begin
                  state <= REQ;   imem_req <= 1'b1;
               end
            end
            REQ: begin
               if (redirect) begin
                  state <= FLUSH; imem_req <= 1'b0;
               end else if (hs && !space_nxt) begin
                  state <= IDLE;  imem_req <= 1'b0;
               end
            end
            FLUSH: begin
               if (redirect) begin
                  state <= FLUSH; imem_req <= 1'b0;
               end else if (space_nxt) begin
                  state <= REQ;   imem_req <= 1'b1;
               end else begin
                  state <= IDLE;  imem_req <= 1'b0;
               end
            end
            default: begin
               state <= IDLE; imem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef IFU_PERF_CNT_EN
   // Popped-entry and starved-consumer cycle counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (pop)                 fetch_cnt  <= fetch_cnt + 32'd1;
         if (pc_en && !valid_out) bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with an in-order memory responder.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, pc_en, redirect, imem_gnt, imem_rvalid;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, valid_out, memc_en;
   logic [31:0] imem_addr, pc_out, instr_out;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt, bubble_cnt;
`endif

   int          tests = 0;
   int          fails = 0;
   int          gcnt  = 0;
   bit          resp_en;
   logic [31:0] exp_pc, a_pc;
   logic [31:0] pend [$];

   instr_fetch_unit dut (
      .clk(clk), .rst(rst), .pc_en(pc_en), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out),
      .memc_en(memc_en)
`ifdef IFU_PERF_CNT_EN
      , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h10) return 32'h0040_000B;
      if (a == 32'h14) return 32'h0000_0013;
      return 32'hA000_0000 | a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock; memory answers each granted address one cycle later when enabled.
   task automatic tick();
      logic        hs_now;
      logic [31:0] a;
      hs_now = imem_req & imem_gnt & ~rst;
      a      = imem_addr;
      @(posedge clk);
      #1;
      if (hs_now) begin
         pend.push_back(a);
         gcnt++;
      end
      if (rst) pend.delete();
      if (resp_en && pend.size() > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem(pend.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
   endtask

   task automatic pop_check();
      if (valid_out && pc_en) begin
         chk("pop_pc", pc_out, exp_pc);
         chk("pop_instr", instr_out, mem(exp_pc));
         chk("memc_en", {31'b0, memc_en}, {31'b0, exp_pc == 32'h10});
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic run_until(input logic [31:0] stop_pc, input int bound);
      for (int i = 0; i < bound && exp_pc != stop_pc; i++) begin
         pop_check();
         tick();
      end
      chk("reach_pc", exp_pc, stop_pc);
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) begin
         pop_check();
         tick();
      end
   endtask

   task automatic wait_req(input int bound);
      for (int i = 0; i < bound && !imem_req; i++) begin
         chk("no_valid_while_flushing", {31'b0, valid_out}, 32'd0);
         tick();
      end
      chk("req_seen", {31'b0, imem_req}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; pc_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; resp_en = 1'b1;
      exp_pc = 32'h0;
      repeat (3) tick();

      // Reset state
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      chk("rst_instr", instr_out, 32'h0000_0013);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_memc", {31'b0, memc_en}, 32'd0);

      // Streaming fetch, grant every cycle, 1-cycle response
      rst = 1'b0; imem_gnt = 1'b1; pc_en = 1'b1;
      tick();
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      tick();
      tick();
      chk("first_valid", {31'b0, valid_out}, 32'd1);
      chk("first_pc", pc_out, 32'h0);
      run_until(32'h20, 60);

      // Drain, then stall with pc_en=0 while the queue fills
      imem_gnt = 1'b0;
      run_n(6);
      chk("drained", {31'b0, valid_out}, 32'd0);
      chk("hold_start_addr", imem_addr, exp_pc);
      a_pc = exp_pc;
      pc_en = 1'b0; imem_gnt = 1'b1; gcnt = 0;
      repeat (5) tick();
      chk("hold_grants", 32'(gcnt), 32'd2);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      chk("hold_valid", {31'b0, valid_out}, 32'd1);
      chk("hold_pc", pc_out, a_pc);
      chk("hold_instr", instr_out, mem(a_pc));
      pc_en = 1'b1;
      run_until(a_pc + 32'd16, 40);

      // Redirect with two fetches outstanding
      imem_gnt = 1'b0;
      run_n(6);
      pc_en = 1'b0; resp_en = 1'b0; imem_gnt = 1'b1;
      repeat (3) tick();
      chk("two_outstanding", 32'(pend.size()), 32'd2);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0; resp_en = 1'b1; pc_en = 1'b1;
      chk("redirect_req_off", {31'b0, imem_req}, 32'd0);
      wait_req(12);
      chk("redirect_addr", imem_addr, 32'h0000_0100);
      exp_pc = 32'h0000_0100;
      run_until(32'h0000_0110, 40);

      // Address wrap at the top of the address space
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      wait_req(12);
      chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr_lo", imem_addr, 32'h0);
      exp_pc = 32'hFFFF_FFFC;
      run_until(32'h8, 40);

      // Reset in the middle of a stream with fetches outstanding
      resp_en = 1'b0;
      repeat (4) tick();
      chk("pre_rst_outstanding", {31'b0, pend.size() > 0}, 32'd1);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", {31'b0, valid_out}, 32'd0);
      chk("mid_rst_instr", instr_out, 32'h0000_0013);
      chk("mid_rst_addr", imem_addr, 32'h0);
      chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
      rst = 1'b0; resp_en = 1'b1;
      exp_pc = 32'h0;
      run_until(32'h8, 40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
